// File: rtl/dfe_out_buffer.sv
// Output FIFO behind the DFE core: show-ahead sample buffer with fill status
// and sticky flags for lost samples and saturated samples.
module dfe_out_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int AFULL_TH   = 12
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         valid_in,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic                         ovf_in,
    input  logic                         unf_in,
    input  logic                         flush,
    input  logic                         clr_status,
    input  logic                         rd_ready,
    output logic                         rd_valid,
    output logic signed [DATA_WIDTH-1:0] rd_data,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         empty,
    output logic                         afull,
    output logic                         drop_err,
    output logic                         sat_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [AW:0] AFULL_LVL = PW'(AFULL_TH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  wr_en;
    logic                  rd_en;
    logic                  drop_set;
    logic                  sat_set;

    // Pointers carry an extra wrap bit so full and empty are distinguishable
    // when the index bits coincide.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign afull    = (count >= AFULL_LVL);
    assign rd_valid = !empty;
    assign rd_data  = mem[rd_ptr[AW-1:0]];

    // Full is taken from registered state, so a same-cycle read never makes
    // room for a write.
    assign wr_en    = valid_in && !full && !flush;
    assign rd_en    = rd_valid && rd_ready && !flush;
    assign drop_set = valid_in && (full || flush);
    assign sat_set  = valid_in && (ovf_in || unf_in);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A set event in the same cycle as clr_status wins over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_err <= 1'b0;
            sat_err  <= 1'b0;
        end else begin
            drop_err <= drop_set || (drop_err && !clr_status);
            sat_err  <= sat_set || (sat_err && !clr_status);
        end
    end

endmodule

// File: tb/tb_dfe_out_buffer.sv
// Self-checking bench for dfe_out_buffer: constant vector table plus directed
// sequences, with a queue scoreboard holding the expected read data.
module tb_dfe_out_buffer;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int ATH   = 12;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic          valid_in;
    logic [DW-1:0] data_in;
    logic          ovf_in;
    logic          unf_in;
    logic          flush;
    logic          clr_status;
    logic          rd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          afull;
    logic          drop_err;
    logic          sat_err;

    int n_checks;
    int n_fail;

    logic [DW-1:0] mdl_q[$];
    logic          mdl_drop;
    logic          mdl_sat;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          o;
        logic          u;
        logic          f;
        logic          c;
        logic          r;
        int            exp_count;
        logic          exp_drop;
        logic          exp_sat;
    } vec_t;

    vec_t vecs[9];

    dfe_out_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_TH(ATH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .valid_in(valid_in),
        .data_in(data_in),
        .ovf_in(ovf_in),
        .unf_in(unf_in),
        .flush(flush),
        .clr_status(clr_status),
        .rd_ready(rd_ready),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .count(count),
        .full(full),
        .empty(empty),
        .afull(afull),
        .drop_err(drop_err),
        .sat_err(sat_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; head data is checked before the edge, status after.
    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic o,
                                 input logic u, input logic f, input logic c, input logic r);
        logic do_wr;
        logic do_rd;
        int   sz;
        valid_in   = v;
        data_in    = d;
        ovf_in     = o;
        unf_in     = u;
        flush      = f;
        clr_status = c;
        rd_ready   = r;
        sz = mdl_q.size();
        checkOutput("rd_valid", 32'(rd_valid), 32'(sz > 0));
        if (sz > 0) begin
            checkOutput("rd_data", 32'(rd_data), 32'(mdl_q[0]));
        end
        do_wr    = v && (sz < DEPTH) && !f;
        do_rd    = (sz > 0) && r && !f;
        mdl_drop = (v && ((sz == DEPTH) || f)) || (mdl_drop && !c);
        mdl_sat  = (v && (o || u)) || (mdl_sat && !c);
        if (f) begin
            mdl_q.delete();
        end else begin
            if (do_rd) void'(mdl_q.pop_front());
            if (do_wr) mdl_q.push_back(d);
        end
        @(posedge clk);
        #1;
        sz = mdl_q.size();
        checkOutput("count", 32'(count), 32'(sz));
        checkOutput("empty", 32'(empty), 32'(sz == 0));
        checkOutput("full", 32'(full), 32'(sz == DEPTH));
        checkOutput("afull", 32'(afull), 32'(sz >= ATH));
        checkOutput("drop_err", 32'(drop_err), 32'(mdl_drop));
        checkOutput("sat_err", 32'(sat_err), 32'(mdl_sat));
    endtask

    task automatic writeWord(input logic [DW-1:0] d);
        applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_count"}, 32'(count), 32'd0);
        checkOutput({tag, "_empty"}, 32'(empty), 32'd1);
        checkOutput({tag, "_full"}, 32'(full), 32'd0);
        checkOutput({tag, "_afull"}, 32'(afull), 32'd0);
        checkOutput({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        checkOutput({tag, "_drop_err"}, 32'(drop_err), 32'd0);
        checkOutput({tag, "_sat_err"}, 32'(sat_err), 32'd0);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        mdl_drop   = 1'b0;
        mdl_sat    = 1'b0;
        rst_n      = 1'b0;
        valid_in   = 1'b0;
        data_in    = '0;
        ovf_in     = 1'b0;
        unf_in     = 1'b0;
        flush      = 1'b0;
        clr_status = 1'b0;
        rd_ready   = 1'b0;

        //     v     d          o     u     f     c     r     cnt drop  sat
        vecs[0] = '{1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 16'h2222, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 16'h3333, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 16'h4444, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 16'h5555, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0};

        #1;
        checkResetOutputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] vector table");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].v, vecs[i].d, vecs[i].o, vecs[i].u, vecs[i].f, vecs[i].c, vecs[i].r);
            checkOutput($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
            checkOutput($sformatf("vec%0d_drop", i), 32'(drop_err), 32'(vecs[i].exp_drop));
            checkOutput($sformatf("vec%0d_sat", i), 32'(sat_err), 32'(vecs[i].exp_sat));
        end

        $display("[TB] fill and drain");
        for (int i = 1; i <= 16; i++) begin
            writeWord(16'(i));
            checkOutput("fill_afull", 32'(afull), 32'(i >= 12));
        end
        checkOutput("fill_full", 32'(full), 32'd1);
        checkOutput("fill_count16", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        checkOutput("drain_empty", 32'(empty), 32'd1);

        $display("[TB] overflow drop");
        for (int i = 0; i < 16; i++) writeWord(16'(16'h0100 + i));
        applyStimulus(1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("ovf_count15", 32'(count), 32'd15);
        checkOutput("ovf_drop", 32'(drop_err), 32'd1);
        checkOutput("ovf_second_oldest", 32'(rd_data), 32'h0101);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("[TB] simultaneous read and write");
        for (int i = 0; i < 5; i++) writeWord(16'(16'h0200 + i));
        for (int i = 5; i < 15; i++) begin
            applyStimulus(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            checkOutput("rw_count5", 32'(count), 32'd5);
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("[TB] pointer wrap");
        for (int i = 0; i < 40; i++) begin
            writeWord(16'(16'h8000 + i));
            applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            checkOutput("wrap_no_full", 32'(full), 32'd0);
        end

        $display("[TB] flush");
        for (int i = 0; i < 7; i++) writeWord(16'(16'h0300 + i));
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("flush_count", 32'(count), 32'd0);
        checkOutput("flush_empty", 32'(empty), 32'd1);
        checkOutput("flush_rd_valid", 32'(rd_valid), 32'd0);

        $display("[TB] asynchronous reset mid-operation");
        applyStimulus(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        writeWord(16'h0401);
        applyStimulus(1'b1, 16'h0402, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        writeWord(16'h0403);
        checkOutput("pre_reset_count", 32'(count), 32'd3);
        #3;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("async_reset");
        mdl_q.delete();
        mdl_drop = 1'b0;
        mdl_sat  = 1'b0;
        valid_in = 1'b1;
        ovf_in   = 1'b1;
        data_in  = 16'hBEEF;
        @(posedge clk);
        #1;
        checkResetOutputs("held_reset");
        valid_in = 1'b0;
        ovf_in   = 1'b0;
        rst_n    = 1'b1;
        writeWord(16'hABCD);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
